// File: rtl/scope_renderer_if.sv
// Audio-in / pixel-out bus between the display block (master) and scope_renderer (slave).
interface scope_renderer_if;
  logic        sample_valid;
  logic [23:0] sample;
  logic [10:0] x;
  logic [9:0]  y;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        capture_busy;

  modport master (
    output sample_valid, sample, x, y,
    input  red, green, blue, capture_busy
  );

  modport slave (
    input  sample_valid, sample, x, y,
    output red, green, blue, capture_busy
  );
endinterface

// File: rtl/scope_renderer.sv
// Oscilloscope stage: zero-crossing triggered, double-buffered column capture, 2-cycle trace render.
// Optional graticule overlay enabled by defining SCOPE_RENDERER_GRID_EN.
module scope_renderer #(
  parameter int          H_ACTIVE    = 1280,
  parameter int          V_ACTIVE    = 720,
  parameter int          DECIM       = 1,
  parameter int          SCALE_SHIFT = 15,
  parameter int          TIMEOUT     = 4096,
  parameter logic [23:0] TRACE_RGB   = 24'h00FF00
) (
  input logic             clk,
  input logic             reset,
  scope_renderer_if.slave bus
);

  localparam logic [1:0] ST_ARMED   = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam int                 TW       = $clog2(TIMEOUT) + 1;
  localparam logic [11:0]        H_ACT    = 12'(H_ACTIVE);
  localparam logic [10:0]        H_LAST   = 11'(H_ACTIVE - 1);
  localparam logic [10:0]        V_ACT    = 11'(V_ACTIVE);
  localparam logic signed [24:0] V_HALF   = 25'(V_ACTIVE / 2);
  localparam logic signed [24:0] V_MAX    = 25'(V_ACTIVE - 1);
  localparam logic [7:0]         DEC_LAST = 8'(DECIM - 1);
  localparam logic [TW-1:0]      TMO_LAST = TW'(TIMEOUT - 1);

  logic [1:0]    state, state_n;
  logic          busy, front_valid, bank, prev_neg;
  logic [10:0]   wptr, waddr, ra;
  logic [7:0]    dec_cnt;
  logic [TW-1:0] tmo;
  logic          swap, accept, dec_hit, trigger, we;
  logic [11:0]   wa, ri;

  logic signed [24:0] samp_ext, shifted, row_s;
  logic [9:0]         row;

  logic [9:0]  mem [0:2*H_ACTIVE-1];
  logic [9:0]  cur, prev_q, prev_eff, lo, hi;
  logic [10:0] x1;
  logic [9:0]  y1;
  logic        active, hit;
  logic [23:0] bg, pix, rgb_q;

  always_comb begin
    samp_ext = {bus.sample[23], bus.sample};
    shifted  = samp_ext >>> SCALE_SHIFT;
    row_s    = V_HALF - shifted;
    if (row_s < 25'sd0)     row = '0;
    else if (row_s > V_MAX) row = V_MAX[9:0];
    else                    row = row_s[9:0];
  end

  // A sample arriving in the swap cycle is discarded entirely, decimation included.
  assign swap    = (state == ST_DONE) && (bus.x == '0) && (bus.y == '0);
  assign accept  = bus.sample_valid && !swap;
  assign dec_hit = accept && (dec_cnt == DEC_LAST);
  assign trigger = (prev_neg && !bus.sample[23]) || (tmo == TMO_LAST);

  always_comb begin
    state_n = state;
    case (state)
      ST_ARMED:   if (dec_hit && trigger)           state_n = ST_CAPTURE;
      ST_CAPTURE: if (dec_hit && (wptr == H_LAST))  state_n = ST_DONE;
      ST_DONE:    if (swap)                         state_n = ST_ARMED;
      default:                                      state_n = ST_ARMED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_ARMED;
      busy        <= 1'b0;
      front_valid <= 1'b0;
      bank        <= 1'b0;
      prev_neg    <= 1'b0;
      wptr        <= '0;
      dec_cnt     <= '0;
      tmo         <= '0;
    end else begin
      state <= state_n;
      busy  <= (state_n != ST_DONE);
      if (accept)  dec_cnt  <= dec_hit ? '0 : dec_cnt + 8'd1;
      if (dec_hit) prev_neg <= bus.sample[23];
      if (dec_hit && state == ST_ARMED) begin
        if (trigger) wptr <= 11'd1;
        else         tmo  <= tmo + TW'(1);
      end
      if (dec_hit && state == ST_CAPTURE) wptr <= wptr + 11'd1;
      if (swap) begin
        bank        <= ~bank;
        front_valid <= 1'b1;
        tmo         <= '0;
      end
    end
  end

  // Bank b occupies mem[b*H_ACTIVE +: H_ACTIVE]; writes go to the back bank (!bank).
  assign we    = dec_hit && (((state == ST_ARMED) && trigger) || (state == ST_CAPTURE));
  assign waddr = (state == ST_ARMED) ? '0 : wptr;
  assign wa    = bank ? {1'b0, waddr} : H_ACT + {1'b0, waddr};
  assign ra    = ({1'b0, bus.x} < H_ACT) ? bus.x : '0;
  assign ri    = bank ? H_ACT + {1'b0, ra} : {1'b0, ra};

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= row;
    cur <= mem[ri];
  end

  always_comb begin
    prev_eff = (x1 == '0) ? cur : prev_q;
    lo       = (prev_eff < cur) ? prev_eff : cur;
    hi       = (prev_eff < cur) ? cur : prev_eff;
    active   = ({1'b0, x1} < H_ACT) && ({1'b0, y1} < V_ACT);
    hit      = front_valid && active && (y1 >= lo) && (y1 <= hi);
  end

`ifdef SCOPE_RENDERER_GRID_EN
  localparam logic [9:0] V_MID = 10'(V_ACTIVE / 2);
  assign bg = (active && ((x1[5:0] == '0) || (y1[5:0] == '0) || (y1 == V_MID))) ? 24'h404040 : '0;
`else
  assign bg = '0;
`endif

  assign pix = hit ? TRACE_RGB : bg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x1     <= '0;
      y1     <= '0;
      prev_q <= '0;
      rgb_q  <= '0;
    end else begin
      x1     <= bus.x;
      y1     <= bus.y;
      prev_q <= cur;
      rgb_q  <= pix;
    end
  end

  assign bus.red          = rgb_q[23:16];
  assign bus.green        = rgb_q[15:8];
  assign bus.blue         = rgb_q[7:0];
  assign bus.capture_busy = busy;

endmodule
